rvfi_imem_model: RTL and testbench
==================================

# rvfi_imem_model

Instruction-fetch memory model for riscv-formal harnesses, placed between the imem consistency checker and the core's instruction-fetch port. Serves fetch requests with a bounded-latency valid/ready handshake. Returns the checker-selected halfword (`imem_data`) at the checker-selected address (`imem_addr`) and unconstrained data everywhere else, so that the checker's assertions are meaningful. Randomness and stall injection come in on ports, so the same RTL runs under formal (free inputs) and in simulation (LFSR-driven).

## Interface

Parameters:
- DEPTH, 2, maximum outstanding fetches (1..4)
- MIN_LATENCY, 1, minimum cycles from request accept to response valid (0..7)
- MAX_STALL, 3, maximum consecutive cycles an eligible response is withheld by `rand_stall` (0..7)

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- imem_addr  in  `RISCV_FORMAL_XLEN  constrained halfword address, from checker
- imem_data  in  16  constrained halfword value, from checker
- rand_data  in  32  free random data, sampled at request accept
- rand_stall  in  1  free random stall request
- fetch_req_valid  in  1  core fetch request
- fetch_req_ready  out  1  model can accept a request
- fetch_req_addr  in  `RISCV_FORMAL_XLEN  byte address of fetch
- fetch_rsp_valid  out  1  response available
- fetch_rsp_ready  in  1  core accepts response
- fetch_rsp_data  out  32  fetched instruction bits
- fetch_rsp_error  out  1  misaligned-address fault

## Operation

- Request accepted on a cycle with `fetch_req_valid && fetch_req_ready`. `fetch_req_ready = (count < DEPTH)`. No same-cycle bypass of a pop: a full queue stays not-ready even if a response retires that cycle.
- At accept, with a = `fetch_req_addr`, compute the entry and push it into an in-order FIFO:
  - lo = (a == imem_addr) ? imem_data : rand_data[15:0]
  - hi = (a+2 == imem_addr) ? imem_data : rand_data[31:16]
  - a+2 is modulo 2^XLEN, so address all-ones-minus-1 wraps to 0.
  - error = a[0]. When error is set, data = 0.
- Each entry carries an age counter. It starts at 0 on push and saturates at MIN_LATENCY. It increments every cycle while the entry is in the FIFO, including while it is not at the head.
- Head is eligible when age >= MIN_LATENCY.
- Head state machine:
  - IDLE: no eligible head.
  - WAIT: eligible, withheld. Entered when eligible && rand_stall && stall_cnt < MAX_STALL. stall_cnt increments each WAIT cycle.
  - PRESENT: `fetch_rsp_valid` = 1. Entered when eligible and (!rand_stall or stall_cnt == MAX_STALL).
- PRESENT is sticky. valid, data and error are held stable until `fetch_rsp_ready`; `rand_stall` is ignored once in PRESENT.
- On `fetch_rsp_valid && fetch_rsp_ready`: pop the head and clear stall_cnt. Next state is PRESENT/WAIT/IDLE, evaluated for the new head in the following cycle. A response never goes back-to-back with its own acceptance cycle.
- Simultaneous push and pop: both take effect and count is unchanged.
- The `imem_addr`/`imem_data` compare is done at accept time only. Later changes to those inputs do not alter queued entries.

## Timing

- Reset (synchronous):
  - count = 0, FIFO empty, state IDLE, stall_cnt = 0
  - `fetch_rsp_valid` = 0, `fetch_rsp_data` = 0, `fetch_rsp_error` = 0, `fetch_req_ready` = 1 (first cycle after reset)
  - A reset mid-operation discards all outstanding entries, including one in PRESENT; the core must not see a response for it.
- Latency, accept cycle t, empty queue, no stalls:
  - MIN_LATENCY=0 → `fetch_rsp_valid` at t+1
  - MIN_LATENCY=L → valid at t+1+L
- Worst-case head latency from eligibility: MAX_STALL cycles.
- Outputs are registered; `fetch_req_ready` is derived from registered count only.

## Test plan

- Hit low halfword: imem_addr=0x100, imem_data=0xA5A5, rand_data=0x12345678; fetch 0x100, MIN_LATENCY=1, no stall → accept at t, valid at t+2, data=0x1234A5A5, error=0.
- Hit high halfword with wrap: XLEN=32, imem_addr=0x0, imem_data=0xBEEF; fetch 0xFFFFFFFE, rand_data=0x0000CAFE → data=0xBEEFCAFE.
- Misaligned: fetch 0x101 → error=1, data=0x00000000, same latency as an aligned fetch.
- Backpressure and stall cap: MAX_STALL=3, rand_stall held 1, rsp_ready=0 for 5 cycles after valid:
  - valid rises exactly 3 cycles after eligibility
  - data stays constant until ready, then pops.
- Full queue: DEPTH=2, two accepts, rsp_ready=0:
  - req_ready=0 on the third cycle
  - pop with concurrent valid request → still not accepted that cycle; accepted the next cycle.
- Reset mid-flight: two entries queued, one PRESENT, reset for 1 cycle → valid=0 the next cycle, req_ready=1, no stale response ever appears.

Source files
------------

// File: rtl/rvfi_imem_model.sv
// rvfi_imem_model
//   Instruction-fetch memory model for riscv-formal harnesses. Sits between
//   the imem consistency checker and the core's fetch port. A fetch request
//   is answered with the checker's halfword wherever the fetch touches the
//   checker's address, and with free random data everywhere else.
//   Randomness and stall injection are plain inputs. Under formal they are
//   left free. In simulation they are driven by an LFSR or by a bench.
//
// Handshakes (both channels): a beat transfers on a cycle where valid and
//   ready are both high at the rising clock edge. Once fetch_rsp_valid
//   rises, it stays high together with fetch_rsp_data and fetch_rsp_error
//   until that transfer happens. fetch_req_ready depends only on the
//   registered occupancy. It never rises because of a pop in the same cycle.
//
// Parameters
//   DEPTH        maximum outstanding fetches (1..4)
//   MIN_LATENCY  minimum cycles from request accept to response valid (0..7)
//   MAX_STALL    maximum consecutive cycles rand_stall may withhold an
//                eligible response (0..7)
//
// Ports
//   clock, reset     clock and synchronous active-high reset
//   imem_addr/data   checker-selected halfword address and value
//   rand_data        free data, sampled when a request is accepted
//   rand_stall       free stall request for an eligible head
//   fetch_req_*      fetch request channel (valid/ready/addr)
//   fetch_rsp_*      fetch response channel (valid/ready/data/error)

`ifndef RISCV_FORMAL_XLEN
`define RISCV_FORMAL_XLEN 32
`endif

module rvfi_imem_model #(
  parameter int DEPTH       = 2,
  parameter int MIN_LATENCY = 1,
  parameter int MAX_STALL   = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [`RISCV_FORMAL_XLEN-1:0] imem_addr,
  input  logic [15:0]                   imem_data,
  input  logic [31:0]                   rand_data,
  input  logic                          rand_stall,
  input  logic                          fetch_req_valid,
  output logic                          fetch_req_ready,
  input  logic [`RISCV_FORMAL_XLEN-1:0] fetch_req_addr,
  output logic                          fetch_rsp_valid,
  input  logic                          fetch_rsp_ready,
  output logic [31:0]                   fetch_rsp_data,
  output logic                          fetch_rsp_error
);

  localparam int XLEN = `RISCV_FORMAL_XLEN;
  localparam int CW   = $clog2(DEPTH + 1);

  localparam logic [2:0]    MIN_L   = 3'(MIN_LATENCY);
  localparam logic [2:0]    MAX_S   = 3'(MAX_STALL);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_PRESENT = 2'd2
  } head_state_t;

  // Entry storage. Slot 0 is always the head. Slots at or above count
  // hold don't-care contents.
  logic [31:0] ent_data [DEPTH];
  logic        ent_err  [DEPTH];
  logic [2:0]  ent_age  [DEPTH];

  logic [31:0] n_data [DEPTH];
  logic        n_err  [DEPTH];
  logic [2:0]  n_age  [DEPTH];

  logic [CW-1:0] count, n_count, cnt_after_pop;
  head_state_t   state, n_state;
  logic [2:0]    stall_cnt, n_stall_cnt, stall_base;

  logic          push, pop, n_eligible;
  logic [XLEN-1:0] addr_plus2;
  logic [15:0]   new_lo, new_hi;
  logic [31:0]   new_data;
  logic          new_err;
  logic [31:0]   n_rsp_data;
  logic          n_rsp_err;

  // Age saturates at MIN_LATENCY, so a 3-bit counter never overflows.
  function automatic logic [2:0] sat_inc(input logic [2:0] a);
    return (a >= MIN_L) ? MIN_L : a + 3'd1;
  endfunction

  assign fetch_req_ready = (count < DEPTH_C);
  assign fetch_rsp_valid = (state == S_PRESENT);

  // Entry built at accept time. The checker compare happens only here, so
  // later changes on imem_addr/imem_data never touch queued entries.
  always_comb begin
    addr_plus2 = fetch_req_addr + XLEN'(2);  // wraps modulo 2^XLEN
    new_lo     = (fetch_req_addr == imem_addr) ? imem_data : rand_data[15:0];
    new_hi     = (addr_plus2 == imem_addr) ? imem_data : rand_data[31:16];
    new_err    = fetch_req_addr[0];
    new_data   = new_err ? 32'h0 : {new_hi, new_lo};
  end

  // Next FIFO contents. A pop shifts every slot down by one. All live
  // entries age by one cycle, whether or not they are at the head. A push
  // lands in the first free slot after the pop.
  always_comb begin
    push          = fetch_req_valid && fetch_req_ready;
    pop           = fetch_rsp_valid && fetch_rsp_ready;
    cnt_after_pop = count - CW'(pop);
    n_count       = count + CW'(push) - CW'(pop);
    for (int i = 0; i < DEPTH; i++) begin
      int src;
      src      = (pop && (i < DEPTH - 1)) ? i + 1 : i;
      n_data[i] = ent_data[src];
      n_err[i]  = ent_err[src];
      n_age[i]  = sat_inc(ent_age[src]);
      if (push && (CW'(i) == cnt_after_pop)) begin
        n_data[i] = new_data;
        n_err[i]  = new_err;
        n_age[i]  = 3'd0;
      end
    end
  end

  // Head state machine. It decides for the head of the next cycle, so the
  // response outputs can be registered and still meet the latency budget.
  always_comb begin
    n_state     = state;
    n_stall_cnt = stall_cnt;
    stall_base  = pop ? 3'd0 : stall_cnt;
    n_eligible  = (n_count != '0) && (n_age[0] >= MIN_L);
    if ((state == S_PRESENT) && !pop) begin
      // Sticky until the core takes the response. rand_stall is ignored.
      n_state     = S_PRESENT;
      n_stall_cnt = stall_cnt;
    end else if (!n_eligible) begin
      n_state     = S_IDLE;
      n_stall_cnt = stall_base;
    end else if (rand_stall && (stall_base < MAX_S)) begin
      n_state     = S_WAIT;
      n_stall_cnt = stall_base + 3'd1;
    end else begin
      n_state     = S_PRESENT;
      n_stall_cnt = stall_base;
    end
    n_rsp_data = (n_state == S_PRESENT) ? n_data[0] : 32'h0;
    n_rsp_err  = (n_state == S_PRESENT) ? n_err[0]  : 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count           <= '0;
      state           <= S_IDLE;
      stall_cnt       <= 3'd0;
      fetch_rsp_data  <= 32'h0;
      fetch_rsp_error <= 1'b0;
    end else begin
      count           <= n_count;
      state           <= n_state;
      stall_cnt       <= n_stall_cnt;
      fetch_rsp_data  <= n_rsp_data;
      fetch_rsp_error <= n_rsp_err;
    end
  end

  // Slot contents need no reset. A zero count marks every slot dead.
  always_ff @(posedge clock) begin
    ent_data <= n_data;
    ent_err  <= n_err;
    ent_age  <= n_age;
  end

endmodule

// File: tb/tb_rvfi_imem_model.sv
module tb_rvfi_imem_model;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic [31:0] rand_data;
  logic        rand_stall;
  logic        fetch_req_valid;
  logic        fetch_req_ready;
  logic [31:0] fetch_req_addr;
  logic        fetch_rsp_valid;
  logic        fetch_rsp_ready;
  logic [31:0] fetch_rsp_data;
  logic        fetch_rsp_error;

  rvfi_imem_model #(.DEPTH(2), .MIN_LATENCY(1), .MAX_STALL(3)) dut (
    .clock           (clock),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .rand_data       (rand_data),
    .rand_stall      (rand_stall),
    .fetch_req_valid (fetch_req_valid),
    .fetch_req_ready (fetch_req_ready),
    .fetch_req_addr  (fetch_req_addr),
    .fetch_rsp_valid (fetch_rsp_valid),
    .fetch_rsp_ready (fetch_rsp_ready),
    .fetch_rsp_data  (fetch_rsp_data),
    .fetch_rsp_error (fetch_rsp_error)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] im_addr;
    logic [15:0] im_data;
    logic [31:0] rnd;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge and outputs are sampled
  // at that point, away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_req_valid = 1'b0;
    fetch_req_addr  = 32'h0;
    fetch_rsp_ready = 1'b0;
    rand_stall      = 1'b0;
    rand_data       = 32'h0;
    imem_addr       = 32'h0;
    imem_data       = 16'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send_req(input logic [31:0] a, input logic [31:0] rnd);
    fetch_req_valid = 1'b1;
    fetch_req_addr  = a;
    rand_data       = rnd;
  endtask

  logic [31:0] held;

  initial begin
    reset = 1'b1;
    idle_inputs();

    // Vectors: {fetch addr, imem_addr, imem_data, rand_data, exp data, exp err}
    vecs[0] = '{32'h0000_0100, 32'h0000_0100, 16'hA5A5, 32'h1234_5678, 32'h1234_A5A5, 1'b0};
    vecs[1] = '{32'hFFFF_FFFE, 32'h0000_0000, 16'hBEEF, 32'h0000_CAFE, 32'hBEEF_CAFE, 1'b0};
    vecs[2] = '{32'h0000_0101, 32'h0000_0100, 16'hA5A5, 32'h1234_5678, 32'h0000_0000, 1'b1};
    vecs[3] = '{32'h0000_00FE, 32'h0000_0100, 16'h1111, 32'hDEAD_BEEF, 32'h1111_BEEF, 1'b0};
    vecs[4] = '{32'h0000_0200, 32'h0000_0100, 16'h2222, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
    vecs[5] = '{32'h0000_0100, 32'h0000_0100, 16'h7777, 32'h0000_0000, 32'h0000_7777, 1'b0};
    vecs[6] = '{32'hFFFF_FFFF, 32'h0000_0001, 16'h3333, 32'h5555_AAAA, 32'h0000_0000, 1'b1};

    // ---- reset state ----
    do_reset();
    check("rst_rsp_valid", {31'b0, fetch_rsp_valid}, 32'd0);
    check("rst_rsp_data",  fetch_rsp_data, 32'h0);
    check("rst_rsp_error", {31'b0, fetch_rsp_error}, 32'd0);
    check("rst_req_ready", {31'b0, fetch_req_ready}, 32'd1);

    // ---- table-driven single fetches, MIN_LATENCY=1, no stall ----
    for (int i = 0; i < 7; i++) begin
      imem_addr = vecs[i].im_addr;
      imem_data = vecs[i].im_data;
      send_req(vecs[i].addr, vecs[i].rnd);
      exp_q.push_back(vecs[i].exp_data);
      tick();  // accept edge (cycle t)
      fetch_req_valid = 1'b0;
      // Disturb the checker and random inputs after accept. The queued
      // entry must keep the values sampled at accept time.
      imem_addr = vecs[i].addr;
      imem_data = ~vecs[i].im_data;
      rand_data = ~vecs[i].rnd;
      check($sformatf("v%0d_valid_t1", i), {31'b0, fetch_rsp_valid}, 32'd0);
      tick();
      check($sformatf("v%0d_valid_t2", i), {31'b0, fetch_rsp_valid}, 32'd1);
      held = exp_q.pop_front();
      check($sformatf("v%0d_data", i), fetch_rsp_data, held);
      check($sformatf("v%0d_error", i), {31'b0, fetch_rsp_error}, {31'b0, vecs[i].exp_err});
      fetch_rsp_ready = 1'b1;
      tick();
      fetch_rsp_ready = 1'b0;
      check($sformatf("v%0d_popped", i), {31'b0, fetch_rsp_valid}, 32'd0);
    end

    // ---- stall cap and backpressure ----
    idle_inputs();
    imem_addr  = 32'h0000_0400;
    imem_data  = 16'h4444;
    rand_stall = 1'b1;
    send_req(32'h0000_0400, 32'h9999_8888);
    tick();  // accept
    fetch_req_valid = 1'b0;
    // Eligible from t+2. Three withheld cycles, then valid at t+5.
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("stall_withheld_t%0d", c), {31'b0, fetch_rsp_valid}, 32'd0);
      tick();
    end
    check("stall_valid_t5", {31'b0, fetch_rsp_valid}, 32'd1);
    check("stall_data", fetch_rsp_data, 32'h9999_4444);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("hold_valid_%0d", c), {31'b0, fetch_rsp_valid}, 32'd1);
      check($sformatf("hold_data_%0d", c), fetch_rsp_data, 32'h9999_4444);
    end
    fetch_rsp_ready = 1'b1;
    tick();
    fetch_rsp_ready = 1'b0;
    rand_stall      = 1'b0;
    check("stall_popped", {31'b0, fetch_rsp_valid}, 32'd0);

    // ---- full queue, no same-cycle bypass of a pop ----
    idle_inputs();
    imem_addr = 32'h0000_1000;
    send_req(32'h0000_0300, 32'h1111_1111);
    tick();                                  // t0: accept A
    send_req(32'h0000_0304, 32'h2222_2222);
    tick();                                  // t1: accept B
    fetch_req_valid = 1'b0;
    check("full_req_ready", {31'b0, fetch_req_ready}, 32'd0);
    check("full_a_valid", {31'b0, fetch_rsp_valid}, 32'd1);
    check("full_a_data", fetch_rsp_data, 32'h1111_1111);
    send_req(32'h0000_0308, 32'h3333_3333);  // t2: offered while full
    fetch_rsp_ready = 1'b1;                  // pop A this cycle
    tick();
    fetch_rsp_ready = 1'b0;
    check("full_b_valid", {31'b0, fetch_rsp_valid}, 32'd1);
    check("full_b_data", fetch_rsp_data, 32'h2222_2222);
    check("full_ready_after_pop", {31'b0, fetch_req_ready}, 32'd1);
    tick();                                  // t3: C accepted now
    fetch_req_valid = 1'b0;
    check("full_again", {31'b0, fetch_req_ready}, 32'd0);
    check("full_b_sticky", fetch_rsp_data, 32'h2222_2222);
    fetch_rsp_ready = 1'b1;
    tick();                                  // B popped
    check("full_c_valid", {31'b0, fetch_rsp_valid}, 32'd1);
    check("full_c_data", fetch_rsp_data, 32'h3333_3333);
    tick();                                  // C popped
    check("full_drained", {31'b0, fetch_rsp_valid}, 32'd0);
    check("full_ready_end", {31'b0, fetch_req_ready}, 32'd1);
    tick();
    check("full_no_extra", {31'b0, fetch_rsp_valid}, 32'd0);
    fetch_rsp_ready = 1'b0;

    // ---- reset mid-flight ----
    idle_inputs();
    send_req(32'h0000_0500, 32'hAAAA_0001);
    tick();
    send_req(32'h0000_0504, 32'hAAAA_0002);
    tick();
    fetch_req_valid = 1'b0;
    check("mid_present", {31'b0, fetch_rsp_valid}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", {31'b0, fetch_rsp_valid}, 32'd0);
    check("mid_rst_ready", {31'b0, fetch_req_ready}, 32'd1);
    check("mid_rst_data", fetch_rsp_data, 32'h0);
    fetch_rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("mid_no_stale_%0d", c), {31'b0, fetch_rsp_valid}, 32'd0);
    end
    fetch_rsp_ready = 1'b0;

    // ---- final report ----
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
